phase_sequencer: RTL and testbench
==================================

# phase_sequencer

Parametrised multi-phase intersection light sequencer. It generalises the single main/side-street traffic FSM to NUM_PHASES approaches, each with its own green, yellow and walk durations, a vehicle-sensor green extension, and a latched pedestrian request. Per-phase interval tables are reprogrammable at run time. The block sits after the synchronizer/debounce stage and is driven by the divider's 1 Hz enable; it has its own internal countdown and does not use the separate timer block.

## Interface
- NUM_PHASES, 4: number of phases, ≥2.
- TW, 4: width of interval values and the countdown.
- DEF_GREEN, 6: reset green time in ticks, applied to all phases.
- DEF_YELLOW, 2: reset yellow time in ticks.
- DEF_WALK, 3: reset walk time in ticks.
- EXT, 3: sensor extension in ticks, granted at most once per green.
- PW = max(1, $clog2(NUM_PHASES)): phase index width.

Ports:
- clk  in  1  system clock; single clock domain.
- g_reset  in  1  reset; synchronous and active-high.
- tick  in  1  one-cycle 1 Hz enable.
- sensor  in  NUM_PHASES  vehicle present, per phase; already synchronised.
- walk_req  in  NUM_PHASES  pedestrian request pulses; already synchronised.
- prog  in  1  one-cycle write strobe.
- prog_phase  in  PW  phase to write.
- prog_sel  in  2  target of the write: 0 = green, 1 = yellow, 2 = walk, 3 = ignored.
- prog_value  in  TW  value to write.
- green  out  NUM_PHASES  one-hot or zero.
- yellow  out  NUM_PHASES  one-hot or zero.
- walk  out  NUM_PHASES  one-hot or zero.
- phase  out  PW  current phase index.
- walk_pending  out  NUM_PHASES  latched pedestrian requests.

## Operation
- States: ALLRED, GREEN, EXTEND, YELLOW, WALK. A phase is red whenever its green and yellow are both low.
- Cycle for phase p: GREEN(p) → optional EXTEND(p) → YELLOW(p) → ALLRED → optional WALK(p) → GREEN(next).
- GREEN lasts green_t[p] ticks. At expiry:
  - if sensor[p] = 1, go to EXTEND for EXT ticks;
  - otherwise go to YELLOW.
- EXTEND drives green[p] high. It always exits to YELLOW, so only one extension is granted per green.
- YELLOW lasts yellow_t[p] ticks.
- ALLRED lasts 1 tick.
  - If walk_pending[p] = 1, go to WALK(p) for walk_t[p] ticks. All green and yellow outputs are low; walk[p] is high. walk_pending[p] clears on WALK entry.
  - Otherwise go straight to GREEN of the next phase.
- Next phase: (p+1) mod NUM_PHASES, skipping any phase whose green_t = 0.
  - If every green_t = 0, remain in ALLRED. Re-evaluate at each tick; pending walks are still served for the current phase index.
- Countdown: loaded with the state's duration on entry, decremented on each tick. The state exits on the tick where the count equals 1.
  - A yellow or walk value of 0 is treated as 1.
  - A green value of 0 only occurs for skipped phases, so it is never loaded as a duration.
- walk_req[i] sets walk_pending[i]. If a set and a clear hit the same bit in the same cycle, the set wins: the bit stays 1.
- prog writes the selected table entry on that clk edge.
  - A countdown already running is not changed; the new value takes effect on the next entry to that state.
  - prog_phase ≥ NUM_PHASES and prog_sel = 3 are ignored.
- Reset:
  - state ALLRED, count 1, phase 0;
  - green, yellow, walk and walk_pending all 0;
  - all tables set to DEF_*.
- If g_reset is asserted mid-interval, it overrides all other inputs in that cycle.

## Timing
- All outputs are registered. They change on the clk edge that samples tick = 1 with count = 1, so they are valid the following cycle.
- First tick after reset: ALLRED → GREEN of the first enabled phase (phase 0 with defaults).
- With no sensor and no walk, a full phase takes green_t + yellow_t + 1 ticks.
- walk_req to walk_pending latency: 1 cycle.
- prog to table update latency: 1 cycle.
- tick asserted for multiple consecutive cycles counts as multiple ticks. Behaviour is defined, but the divider is expected to produce single-cycle pulses.
- Inputs are ignored while g_reset is high. Ticks arriving during reset are lost.

## Test plan
- Defaults, no inputs, tick every 4 clk: green[0] for 6 ticks, yellow[0] for 2, all red for 1, then green[1]; phase wraps 3 → 0 after 36 ticks.
- sensor[1] held high through green 1: green[1] lasts 9 ticks, not 6; yellow follows with no second extension.
- walk_req[2] pulsed during green 0: walk_pending = 4'b0100 the next cycle. After ALLRED following yellow[2], walk[2] is high for 3 ticks and pending clears. A walk_req[2] pulse on the clearing cycle leaves pending set.
- prog sets green of phase 1 to 0: the sequence runs 0 → 2 → 3 → 0. Setting all greens to 0 holds ALLRED indefinitely, with all outputs red.
- prog sets yellow of phase 0 to 5 while in yellow(0) with count 2: the current yellow ends after 2 more ticks; the next yellow(0) lasts 5 ticks. A yellow value of 0 yields a 1-tick yellow.
- Assert g_reset during WALK(3) with pending bits set: all outputs and walk_pending read 0, phase reads 0, and the tables return to defaults.

Source files
------------

// File: rtl/phase_sequencer_if.sv
// phase_sequencer_if: sensor, request, programming and lamp signals of the sequencer
interface phase_sequencer_if #(
  parameter int NUM_PHASES = 4,
  parameter int TW = 4,
  parameter int PW = ($clog2(NUM_PHASES) > 1) ? $clog2(NUM_PHASES) : 1
);
  logic tick;
  logic [NUM_PHASES-1:0] sensor;
  logic [NUM_PHASES-1:0] walk_req;
  logic prog;
  logic [PW-1:0] prog_phase;
  logic [1:0] prog_sel;
  logic [TW-1:0] prog_value;
  logic [NUM_PHASES-1:0] green;
  logic [NUM_PHASES-1:0] yellow;
  logic [NUM_PHASES-1:0] walk;
  logic [PW-1:0] phase;
  logic [NUM_PHASES-1:0] walk_pending;
  modport master (
    output tick, sensor, walk_req, prog, prog_phase, prog_sel, prog_value,
    input green, yellow, walk, phase, walk_pending
  );
  modport slave (
    input tick, sensor, walk_req, prog, prog_phase, prog_sel, prog_value,
    output green, yellow, walk, phase, walk_pending
  );
endinterface

// File: rtl/phase_sequencer.sv
// phase_sequencer: multi-phase intersection light sequencer with extension, walk and programmable intervals
module phase_sequencer #(
  parameter int NUM_PHASES = 4,
  parameter int TW = 4,
  parameter int DEF_GREEN = 6,
  parameter int DEF_YELLOW = 2,
  parameter int DEF_WALK = 3,
  parameter int EXT = 3,
  parameter int PW = ($clog2(NUM_PHASES) > 1) ? $clog2(NUM_PHASES) : 1
) (
  input logic clk,
  input logic g_reset,
  phase_sequencer_if.slave bus
);
  typedef enum logic [2:0] {ALLRED, GREEN, EXTEND, YELLOW, WALK} state_t;
  localparam logic [TW-1:0] EXT_T = (EXT < 1) ? TW'(1) : TW'(EXT);
  state_t state_q, state_d;
  logic [TW-1:0] count_q, count_d;
  logic [PW-1:0] phase_q, phase_d, nxt, c;
  logic first_q, first_d, any_en;
  logic [NUM_PHASES-1:0] pend_q, pend_d, clr, onehot;
  logic [NUM_PHASES-1:0] green_q, yellow_q, walk_q;
  logic [TW-1:0] green_t_q [NUM_PHASES];
  logic [TW-1:0] yellow_t_q [NUM_PHASES];
  logic [TW-1:0] walk_t_q [NUM_PHASES];
  logic [TW-1:0] yel_dur, walk_dur;
  assign yel_dur = (yellow_t_q[phase_q] == '0) ? TW'(1) : yellow_t_q[phase_q];
  assign walk_dur = (walk_t_q[phase_q] == '0) ? TW'(1) : walk_t_q[phase_q];
  assign pend_d = (pend_q & ~clr) | bus.walk_req;
  assign onehot = NUM_PHASES'(1) << phase_d;
  assign bus.green = green_q;
  assign bus.yellow = yellow_q;
  assign bus.walk = walk_q;
  assign bus.phase = phase_q;
  assign bus.walk_pending = pend_q;
  // nearest enabled phase; before the first green the current phase itself is a candidate
  always_comb begin
    nxt = phase_q;
    any_en = 1'b0;
    c = '0;
    for (int k = NUM_PHASES; k >= 1; k--) begin
      c = PW'((int'(phase_q) + k - int'(first_q)) % NUM_PHASES);
      if (green_t_q[c] != '0) begin
        nxt = c;
        any_en = 1'b1;
      end
    end
  end
  // countdown and state transitions, all taken on a tick that finds the count at 1
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    phase_d = phase_q;
    first_d = first_q;
    clr = '0;
    if (bus.tick && count_q > TW'(1)) count_d = count_q - TW'(1);
    else if (bus.tick) begin
      case (state_q)
        ALLRED: begin
          if (pend_q[phase_q]) begin
            state_d = WALK;
            count_d = walk_dur;
            clr[phase_q] = 1'b1;
          end else if (any_en) begin
            state_d = GREEN;
            phase_d = nxt;
            count_d = green_t_q[nxt];
            first_d = 1'b0;
          end
        end
        GREEN: begin
          state_d = bus.sensor[phase_q] ? EXTEND : YELLOW;
          count_d = bus.sensor[phase_q] ? EXT_T : yel_dur;
        end
        EXTEND: begin
          state_d = YELLOW;
          count_d = yel_dur;
        end
        YELLOW: begin
          state_d = ALLRED;
          count_d = TW'(1);
        end
        default: begin
          state_d = any_en ? GREEN : ALLRED;
          phase_d = any_en ? nxt : phase_q;
          count_d = any_en ? green_t_q[nxt] : TW'(1);
          first_d = first_q & ~any_en;
        end
      endcase
    end
  end
  // state, registered lamps, pending requests and the interval tables
  always_ff @(posedge clk) begin
    if (g_reset) begin
      state_q <= ALLRED;
      count_q <= TW'(1);
      phase_q <= '0;
      first_q <= 1'b1;
      pend_q <= '0;
      green_q <= '0;
      yellow_q <= '0;
      walk_q <= '0;
      for (int i = 0; i < NUM_PHASES; i++) begin
        green_t_q[i] <= TW'(DEF_GREEN);
        yellow_t_q[i] <= TW'(DEF_YELLOW);
        walk_t_q[i] <= TW'(DEF_WALK);
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      phase_q <= phase_d;
      first_q <= first_d;
      pend_q <= pend_d;
      green_q <= (state_d == GREEN || state_d == EXTEND) ? onehot : '0;
      yellow_q <= (state_d == YELLOW) ? onehot : '0;
      walk_q <= (state_d == WALK) ? onehot : '0;
      if (bus.prog && 32'(bus.prog_phase) < NUM_PHASES) begin
        if (bus.prog_sel == 2'd0) green_t_q[bus.prog_phase] <= bus.prog_value;
        if (bus.prog_sel == 2'd1) yellow_t_q[bus.prog_phase] <= bus.prog_value;
        if (bus.prog_sel == 2'd2) walk_t_q[bus.prog_phase] <= bus.prog_value;
      end
    end
  end
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: directed scenarios plus random traffic checked against a tick-level lamp model
module tb_phase_sequencer;
  localparam int N = 4;
  localparam int TW = 4;
  localparam int PW = 2;
  logic clk = 1'b0;
  logic g_reset;
  int checks = 0;
  int fails = 0;
  int m_kind;
  int m_left;
  int m_ph;
  bit m_ext;
  bit m_started;
  int g_t [N];
  int y_t [N];
  int w_t [N];
  logic [N-1:0] m_pend;
  phase_sequencer_if #(.NUM_PHASES(N), .TW(TW)) bus ();
  phase_sequencer #(.NUM_PHASES(N), .TW(TW), .DEF_GREEN(6), .DEF_YELLOW(2), .DEF_WALK(3), .EXT(3)) dut (
    .clk(clk),
    .g_reset(g_reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [N-1:0] lamp(int kind);
    return (m_kind == kind) ? (N'(1) << m_ph) : '0;
  endfunction
  function automatic int atleast1(int v);
    return (v == 0) ? 1 : v;
  endfunction
  function automatic int next_enabled();
    for (int k = 0; k < N; k++) begin
      int p;
      p = (m_ph + k + (m_started ? 1 : 0)) % N;
      if (g_t[p] != 0) return p;
    end
    return -1;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      g_t[i] = 6;
      y_t[i] = 2;
      w_t[i] = 3;
    end
    m_kind = 0;
    m_left = 1;
    m_ph = 0;
    m_ext = 0;
    m_started = 0;
    m_pend = '0;
  endtask
  // kinds: 0 all red, 1 green, 2 yellow, 3 walk
  task automatic model_tick(logic [N-1:0] sens);
    int n;
    if (m_left > 1) begin
      m_left--;
      return;
    end
    n = next_enabled();
    if (m_kind == 0 && m_pend[m_ph]) begin
      m_kind = 3;
      m_left = atleast1(w_t[m_ph]);
      m_pend[m_ph] = 1'b0;
    end else if (m_kind == 0 || m_kind == 3) begin
      if (n >= 0) begin
        m_kind = 1;
        m_ph = n;
        m_left = g_t[n];
        m_ext = 0;
        m_started = 1;
      end else begin
        m_kind = 0;
        m_left = 1;
      end
    end else if (m_kind == 1 && !m_ext && sens[m_ph]) begin
      m_ext = 1;
      m_left = 3;
    end else if (m_kind == 1) begin
      m_kind = 2;
      m_left = atleast1(y_t[m_ph]);
    end else begin
      m_kind = 0;
      m_left = 1;
    end
  endtask
  task automatic cycle(bit tk, logic [N-1:0] sens, logic [N-1:0] wr, bit pg, int pph, int psel, int pval, bit rst);
    g_reset = rst;
    bus.tick = tk;
    bus.sensor = sens;
    bus.walk_req = wr;
    bus.prog = pg;
    bus.prog_phase = PW'(pph);
    bus.prog_sel = 2'(psel);
    bus.prog_value = TW'(pval);
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (tk) model_tick(sens);
      if (pg && pph < N) begin
        if (psel == 0) g_t[pph] = pval;
        else if (psel == 1) y_t[pph] = pval;
        else if (psel == 2) w_t[pph] = pval;
      end
      m_pend = m_pend | wr;
    end
    @(negedge clk);
    check("green", bus.green, lamp(1));
    check("yellow", bus.yellow, lamp(2));
    check("walk", bus.walk, lamp(3));
    check("phase", bus.phase, m_ph);
    check("pending", bus.walk_pending, m_pend);
  endtask
  task automatic idle(int n);
    repeat (n) cycle(0, '0, '0, 0, 0, 0, 0, 0);
  endtask
  task automatic tk(logic [N-1:0] sens, logic [N-1:0] wr);
    cycle(1, sens, wr, 0, 0, 0, 0, 0);
    idle(3);
  endtask
  task automatic prog_w(int pph, int psel, int pval);
    cycle(0, '0, '0, 1, pph, psel, pval, 0);
  endtask
  task automatic measure_y0(output int len);
    bit found;
    found = 0;
    len = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      tk('0, '0);
      found = (bus.yellow == 4'b0001);
    end
    if (found) begin
      len = 1;
      for (int i = 0; i < 20 && bus.yellow == 4'b0001; i++) begin
        tk('0, '0);
        if (bus.yellow == 4'b0001) len++;
      end
    end
  endtask
  initial begin
    int n;
    bit found, saw1, saw2;
    model_reset();
    g_reset = 1'b1;
    bus.tick = 1'b0;
    bus.sensor = '0;
    bus.walk_req = '0;
    bus.prog = 1'b0;
    bus.prog_phase = '0;
    bus.prog_sel = '0;
    bus.prog_value = '0;
    @(negedge clk);
    cycle(0, '0, '0, 0, 0, 0, 0, 1);
    cycle(0, '0, '0, 0, 0, 0, 0, 1);
    check("rst_lamps", {bus.green, bus.yellow, bus.walk, bus.walk_pending}, 16'h0);
    check("rst_phase", bus.phase, 0);
    tk('0, '0);
    check("first_green", bus.green, 4'b0001);
    repeat (8) tk('0, '0);
    check("allred_gap", {bus.green, bus.yellow}, 8'h0);
    tk('0, '0);
    check("second_green", bus.green, 4'b0010);
    repeat (27) tk('0, '0);
    check("wrap_phase", bus.phase, 0);
    check("wrap_green", bus.green, 4'b0001);
    n = 0;
    repeat (21) begin
      tk(4'b0010, '0);
      if (bus.green == 4'b0010) n++;
    end
    check("ext_len", n, 9);
    cycle(0, '0, 4'b0100, 0, 0, 0, 0, 0);
    check("wreq_latch", bus.walk_pending, 4'b0100);
    repeat (8) tk('0, '0);
    tk('0, 4'b0100);
    check("walk_on", bus.walk, 4'b0100);
    check("walk_set_wins", bus.walk_pending, 4'b0100);
    n = 0;
    repeat (3) begin
      tk('0, '0);
      if (bus.walk == 4'b0100) n++;
    end
    check("walk_len", n, 2);
    check("after_walk", bus.green, 4'b1000);
    prog_w(1, 0, 0);
    saw1 = 0;
    saw2 = 0;
    repeat (40) begin
      tk('0, '0);
      if (bus.green[1]) saw1 = 1;
      if (bus.green[2]) saw2 = 1;
    end
    check("skip1", saw1, 0);
    check("saw2", saw2, 1);
    prog_w(0, 0, 0);
    prog_w(2, 0, 0);
    prog_w(3, 0, 0);
    repeat (15) tk('0, '0);
    n = 0;
    repeat (10) begin
      tk('0, '0);
      if ((bus.green | bus.yellow) != '0) n++;
    end
    check("all_red_hold", n, 0);
    for (int p = 0; p < N; p++) prog_w(p, 0, 6);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      tk('0, '0);
      found = (bus.yellow == 4'b0001);
    end
    check("find_y0", found, 1);
    prog_w(0, 1, 5);
    tk('0, '0);
    check("y0_running", bus.yellow, 4'b0001);
    tk('0, '0);
    check("y0_end", bus.yellow, 4'b0000);
    measure_y0(n);
    check("y0_len5", n, 5);
    prog_w(0, 1, 0);
    measure_y0(n);
    check("y0_len1", n, 1);
    cycle(0, '0, '0, 0, 0, 0, 0, 1);
    repeat (2000) cycle($urandom_range(0, 3) == 0, N'($urandom), ($urandom_range(0, 9) == 0) ? N'($urandom) : '0,
                        $urandom_range(0, 9) == 0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15),
                        $urandom_range(0, 149) == 0);
    cycle(0, '0, '0, 0, 0, 0, 0, 1);
    cycle(0, '0, 4'b1000, 0, 0, 0, 0, 0);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      tk('0, '0);
      found = (bus.walk == 4'b1000);
    end
    check("find_walk3", found, 1);
    cycle(0, '0, 4'b0111, 0, 0, 0, 0, 0);
    cycle(0, '0, 4'b0110, 0, 0, 0, 0, 1);
    check("mid_rst_lamps", {bus.green, bus.yellow, bus.walk, bus.walk_pending}, 16'h0);
    check("mid_rst_phase", bus.phase, 0);
    repeat (6) tk('0, '0);
    check("def_green", bus.green, 4'b0001);
    tk('0, '0);
    check("def_yellow", bus.yellow, 4'b0001);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
